regfile_wb_arbiter: RTL

Writeback stage directly upstream of the register file write port. Merges two writeback producers into the single registered write port (we/waddr/wdata):
- Source A: single-cycle ALU.
- Source B: long-latency unit (load/mul/div).
Each source uses a valid/ready handshake. Source A has fixed priority, and a starvation counter guarantees Source B forward progress.

---
 rtl/regfile_wb_arbiter.sv | 100 ++++++++++
 1 files changed

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter feeding the register file write port.
// Source A (single-cycle ALU) has fixed priority. Source B (load/mul/div) is
// forced to win once it has been refused STARVE_LIMIT consecutive cycles.
// The write port is registered, so a writeback appears one cycle after it is accepted.
module regfile_wb_arbiter #(
  parameter int ADDR_WIDTH   = 5,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  a_valid_i,
  output logic                  a_ready_o,
  input  logic [ADDR_WIDTH-1:0] a_addr_i,
  input  logic [DATA_WIDTH-1:0] a_data_i,
  input  logic                  b_valid_i,
  output logic                  b_ready_o,
  input  logic [ADDR_WIDTH-1:0] b_addr_i,
  input  logic [DATA_WIDTH-1:0] b_data_i,
  output logic                  we_o,
  output logic [ADDR_WIDTH-1:0] waddr_o,
  output logic [DATA_WIDTH-1:0] wdata_o
);

  localparam int                CNT_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0]  LIMIT_C = CNT_W'(STARVE_LIMIT);

  logic                  run_q;
  logic [CNT_W-1:0]      starve_cnt_q, starve_cnt_d;
  logic                  force_b;
  logic                  grant_a, grant_b;
  logic                  we_d;
  logic [ADDR_WIDTH-1:0] waddr_d;
  logic [DATA_WIDTH-1:0] wdata_d;
  logic                  xfer;

  // Grant: A wins ties unless B has starved long enough; nothing granted until run is set.
  always_comb begin
    force_b = (starve_cnt_q >= LIMIT_C);
    grant_a = run_q & a_valid_i & (~b_valid_i | ~force_b);
    grant_b = run_q & b_valid_i & (~a_valid_i | force_b);
  end

  assign a_ready_o = grant_a;
  assign b_ready_o = grant_b;
  assign xfer      = grant_a | grant_b;

  // Starvation counter: restarts whenever B wins or stops asking, else counts refusals.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!b_valid_i || grant_b) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q < LIMIT_C) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end
  end

  // Next write-port contents: winner's payload; address 0 is consumed but never written.
  always_comb begin
    waddr_d = waddr_o;
    wdata_d = wdata_o;
    we_d    = 1'b0;
    if (grant_b) begin
      waddr_d = b_addr_i;
      wdata_d = b_data_i;
      we_d    = (b_addr_i != '0);
    end else if (grant_a) begin
      waddr_d = a_addr_i;
      wdata_d = a_data_i;
      we_d    = (a_addr_i != '0);
    end
  end

  // Run flag and starvation state; run sets on the first edge after reset release.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      run_q        <= 1'b0;
      starve_cnt_q <= '0;
    end else begin
      run_q        <= 1'b1;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  // Registered write port; address/data hold when there is no transfer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      we_o    <= 1'b0;
      waddr_o <= '0;
      wdata_o <= '0;
    end else begin
      we_o <= we_d;
      if (xfer) begin
        waddr_o <= waddr_d;
        wdata_o <= wdata_d;
      end
    end
  end

endmodule
